// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking-lot day controller.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPEN    = 2'd1,
        ST_CLOSING = 2'd2,
        ST_DONE    = 2'd3
    } day_state_t;

    localparam int HOURS_PER_DAY    = 8;
    localparam int DEFAULT_CAPACITY = 3;

endpackage

// File: rtl/parking_gate_arbiter.sv
// Two-requester gate arbiter: alternating priority, and the gate is busy for
// one cycle after any grant so grants are at least two cycles apart.
module parking_gate_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_entry_elig,
    input  logic i_exit_elig,
    output logic o_entry_take,
    output logic o_exit_take,
    output logic o_entry_grant,
    output logic o_exit_grant
);

    logic r_entry_grant;
    logic r_exit_grant;
    logic r_prio_exit;
    logic w_busy;

    assign w_busy = r_entry_grant | r_exit_grant;

    // Decision for this edge; the top uses it to update occupancy on the
    // same edge that raises the registered grant.
    assign o_entry_take = !w_busy && i_entry_elig && (!i_exit_elig || !r_prio_exit);
    assign o_exit_take  = !w_busy && i_exit_elig  && (!i_entry_elig || r_prio_exit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_entry_grant <= 1'b0;
            r_exit_grant  <= 1'b0;
            r_prio_exit   <= 1'b1;
        end else begin
            r_entry_grant <= o_entry_take;
            r_exit_grant  <= o_exit_take;
            if (i_clear)
                r_prio_exit <= 1'b1;
            else if (o_entry_take)
                r_prio_exit <= 1'b1;
            else if (o_exit_take)
                r_prio_exit <= 1'b0;
        end
    end

    assign o_entry_grant = r_entry_grant;
    assign o_exit_grant  = r_exit_grant;

endmodule

// File: rtl/parking_day_ctrl.sv
// Day sequencer (IDLE/OPEN/CLOSING/DONE), hour counter and occupancy tracker.
// Define PARKING_RUSH_LOG_EN to capture the first hour the lot fills.
module parking_day_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY = DEFAULT_CAPACITY,
    parameter int HOURS    = HOURS_PER_DAY
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         hour_tick,
    input  logic                         arrive_req,
    input  logic                         depart_req,
    output logic                         entry_grant,
    output logic                         exit_grant,
    output logic [2:0]                   hour,
    output logic [$clog2(CAPACITY+1)-1:0] occupancy,
    output logic                         full,
    output logic                         lot_open,
    output logic                         day_done,
    output logic [2:0]                   rush_hour,
    output logic                         rush_valid
);

    localparam int              OW        = $clog2(CAPACITY+1);
    localparam logic [OW-1:0]   CAP_V     = OW'(CAPACITY);
    localparam logic [2:0]      HOUR_LAST = 3'(HOURS-1);

    day_state_t    r_state;
    day_state_t    w_state_nxt;
    logic [2:0]    r_hour;
    logic [OW-1:0] r_occ;
    logic [OW-1:0] w_occ_nxt;
    logic          r_full;
    logic          r_lot_open;
    logic          r_day_done;

    logic w_start_take;
    logic w_tick_open;
    logic w_last_hour;
    logic w_entry_elig;
    logic w_exit_elig;
    logic w_entry_take;
    logic w_exit_take;
    logic w_entry_grant;
    logic w_exit_grant;
    logic w_in_flight;

    assign w_start_take = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_tick_open  = hour_tick && (r_state == ST_OPEN);
    assign w_last_hour  = (r_hour == HOUR_LAST);
    assign w_entry_elig = (r_state == ST_OPEN) && arrive_req && !r_full;
    assign w_exit_elig  = (r_state == ST_OPEN || r_state == ST_CLOSING)
                          && depart_req && (r_occ != '0);
    assign w_in_flight  = w_entry_grant | w_exit_grant;

    parking_gate_arbiter u_arb (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_start_take),
        .i_entry_elig  (w_entry_elig),
        .i_exit_elig   (w_exit_elig),
        .o_entry_take  (w_entry_take),
        .o_exit_take   (w_exit_take),
        .o_entry_grant (w_entry_grant),
        .o_exit_grant  (w_exit_grant)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_start_take) w_state_nxt = ST_OPEN;
            ST_OPEN:          if (w_tick_open && w_last_hour) w_state_nxt = ST_CLOSING;
            // Wait out the last exit pulse so the gate is closed before DONE.
            ST_CLOSING:       if (r_occ == '0 && !w_in_flight) w_state_nxt = ST_DONE;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_start_take)
            w_occ_nxt = '0;
        else if (w_entry_take)
            w_occ_nxt = r_occ + 1'b1;
        else if (w_exit_take)
            w_occ_nxt = r_occ - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hour     <= 3'd0;
            r_occ      <= '0;
            r_full     <= 1'b0;
            r_lot_open <= 1'b0;
            r_day_done <= 1'b0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_full     <= (w_occ_nxt == CAP_V);
            r_lot_open <= (w_state_nxt == ST_OPEN);
            r_day_done <= (w_state_nxt == ST_DONE);
            if (w_start_take)
                r_hour <= 3'd0;
            else if (w_tick_open && !w_last_hour)
                r_hour <= r_hour + 3'd1;
        end
    end

`ifdef PARKING_RUSH_LOG_EN
    logic [2:0] r_rush_hour;
    logic       r_rush_valid;

    always_ff @(posedge clk) begin
        if (reset || w_start_take) begin
            r_rush_hour  <= 3'd0;
            r_rush_valid <= 1'b0;
        end else if (w_entry_take && (w_occ_nxt == CAP_V) && !r_rush_valid) begin
            r_rush_hour  <= r_hour;
            r_rush_valid <= 1'b1;
        end
    end

    assign rush_hour  = r_rush_hour;
    assign rush_valid = r_rush_valid;
`else
    assign rush_hour  = 3'd0;
    assign rush_valid = 1'b0;
`endif

    assign entry_grant = w_entry_grant;
    assign exit_grant  = w_exit_grant;
    assign hour        = r_hour;
    assign occupancy   = r_occ;
    assign full        = r_full;
    assign lot_open    = r_lot_open;
    assign day_done    = r_day_done;

endmodule

// File: tb/tb_parking_day_ctrl.sv
// Scenario bench for parking_day_ctrl; expected grants are queued per scenario
// and retired as the DUT pulses its grant outputs.
module tb_parking_day_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       hour_tick = 1'b0;
    logic       arrive_req = 1'b0;
    logic       depart_req = 1'b0;
    logic       entry_grant, exit_grant;
    logic [2:0] hour;
    logic [1:0] occupancy;
    logic       full, lot_open, day_done;
    logic [2:0] rush_hour;
    logic       rush_valid;

    parking_day_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .hour_tick(hour_tick),
        .arrive_req(arrive_req), .depart_req(depart_req),
        .entry_grant(entry_grant), .exit_grant(exit_grant),
        .hour(hour), .occupancy(occupancy), .full(full),
        .lot_open(lot_open), .day_done(day_done),
        .rush_hour(rush_hour), .rush_valid(rush_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_exit;
        int occ;
    } exp_t;

    exp_t sb[$];
    int   g_cyc[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_n = 0;

`ifdef PARKING_RUSH_LOG_EN
    localparam bit RUSH_EN = 1'b1;
`else
    localparam bit RUSH_EN = 1'b0;
`endif

    // One clock: outputs sampled on the falling edge, inputs changed there too.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        if (entry_grant || exit_grant) begin
            n_vec++;
            g_cyc.push_back(cyc_n);
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_grant: entry=%0b exit=%0b occ=%0d, required no grant",
                         entry_grant, exit_grant, occupancy);
            end else begin
                e = sb.pop_front();
                if (entry_grant !== !e.is_exit || exit_grant !== e.is_exit ||
                    int'(occupancy) !== e.occ) begin
                    n_err++;
                    $display("FAIL grant: entry=%0b exit=%0b occ=%0d, required exit=%0b occ=%0d",
                             entry_grant, exit_grant, occupancy, e.is_exit, e.occ);
                end
            end
        end
    endtask

    task automatic push(input bit is_exit, input int occ);
        exp_t e;
        e.is_exit = is_exit;
        e.occ     = occ;
        sb.push_back(e);
    endtask

    task automatic sb_drained(input string name);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_grants: %0d outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Hold one request until n grants have been issued (2n-1 edges), then idle.
    task automatic burst(input bit is_exit, input int n, input int occ0);
        for (int i = 0; i < n; i++)
            push(is_exit, is_exit ? occ0 - 1 - i : occ0 + 1 + i);
        if (is_exit) depart_req = 1'b1; else arrive_req = 1'b1;
        repeat (2*n - 1) cyc();
        depart_req = 1'b0;
        arrive_req = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_tick();
        hour_tick = 1'b1;
        cyc();
        hour_tick = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({entry_grant, exit_grant, hour, occupancy, full, lot_open, day_done,
             rush_hour, rush_valid} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs: eg=%0b xg=%0b hour=%0d occ=%0d full=%0b open=%0b done=%0b rh=%0d rv=%0b, required all 0",
                     entry_grant, exit_grant, hour, occupancy, full, lot_open, day_done,
                     rush_hour, rush_valid);
        end
        start = 1'b0;
        cyc();
        n_vec++;
        if (lot_open !== 1'b0) begin
            n_err++;
            $display("FAIL idle_without_start: lot_open=%0b, required 0", lot_open);
        end
    endtask

    task automatic test_fill();
        do_start();
        n_vec++;
        if (lot_open !== 1'b1 || hour !== 3'd0) begin
            n_err++;
            $display("FAIL start_open: lot_open=%0b hour=%0d, required 1 0", lot_open, hour);
        end
        g_cyc.delete();
        push(1'b0, 1); push(1'b0, 2); push(1'b0, 3);
        arrive_req = 1'b1;
        repeat (8) cyc();
        arrive_req = 1'b0;
        cyc();
        sb_drained("fill");
        n_vec++;
        if (g_cyc.size() != 3 || g_cyc[1] - g_cyc[0] != 2 || g_cyc[2] - g_cyc[1] != 2) begin
            n_err++;
            $display("FAIL fill_spacing: %0d grants, required 3 grants 2 cycles apart", g_cyc.size());
        end
        n_vec++;
        if (full !== 1'b1 || occupancy !== 2'd3) begin
            n_err++;
            $display("FAIL fill_full: full=%0b occ=%0d, required 1 3", full, occupancy);
        end
    endtask

    task automatic test_both();
        do_reset();
        do_start();
        burst(1'b0, 2, 0);
        // Pointer favours exit again after two entry grants.
        push(1'b1, 1); push(1'b0, 2);
        arrive_req = 1'b1;
        depart_req = 1'b1;
        repeat (3) cyc();
        arrive_req = 1'b0;
        depart_req = 1'b0;
        cyc();
        sb_drained("both");
        n_vec++;
        if (occupancy !== 2'd2 || full !== 1'b0) begin
            n_err++;
            $display("FAIL both_occ: occ=%0d full=%0b, required 2 0", occupancy, full);
        end
    endtask

    task automatic test_day_end();
        do_reset();
        do_start();
        burst(1'b0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            do_tick();
            n_vec++;
            if (hour !== 3'(i < 7 ? i + 1 : 7)) begin
                n_err++;
                $display("FAIL hour_count: tick %0d hour=%0d, required %0d", i, hour, i < 7 ? i + 1 : 7);
            end
        end
        n_vec++;
        if (lot_open !== 1'b0 || day_done !== 1'b0) begin
            n_err++;
            $display("FAIL closing_state: open=%0b done=%0b, required 0 0", lot_open, day_done);
        end
        arrive_req = 1'b1;
        repeat (4) cyc();
        arrive_req = 1'b0;
        do_tick();
        n_vec++;
        if (hour !== 3'd7) begin
            n_err++;
            $display("FAIL hour_closing_tick: hour=%0d, required 7", hour);
        end
        push(1'b1, 0);
        depart_req = 1'b1;
        cyc();
        depart_req = 1'b0;
        cyc();
        n_vec++;
        if (day_done !== 1'b0) begin
            n_err++;
            $display("FAIL done_early: day_done=%0b with exit in flight, required 0", day_done);
        end
        cyc();
        sb_drained("day_end");
        n_vec++;
        if (day_done !== 1'b1 || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL day_done: done=%0b occ=%0d, required 1 0", day_done, occupancy);
        end
    endtask

    task automatic test_empty_close();
        do_start();
        n_vec++;
        if (lot_open !== 1'b1 || day_done !== 1'b0 || hour !== 3'd0 || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL restart: open=%0b done=%0b hour=%0d occ=%0d, required 1 0 0 0",
                     lot_open, day_done, hour, occupancy);
        end
        for (int i = 0; i < 8; i++) begin
            hour_tick = 1'b1;
            cyc();
            hour_tick = 1'b0;
            if (i == 7) begin
                n_vec++;
                if (lot_open !== 1'b0 || day_done !== 1'b0) begin
                    n_err++;
                    $display("FAIL empty_closing: open=%0b done=%0b, required 0 0", lot_open, day_done);
                end
            end
            cyc();
        end
        n_vec++;
        if (day_done !== 1'b1) begin
            n_err++;
            $display("FAIL empty_done: day_done=%0b, required 1", day_done);
        end
    endtask

    task automatic test_rush();
        do_reset();
        do_start();
        do_tick();
        do_tick();
        burst(1'b0, 3, 0);
        n_vec++;
        if (rush_hour !== (RUSH_EN ? 3'd2 : 3'd0) || rush_valid !== RUSH_EN) begin
            n_err++;
            $display("FAIL rush_capture: rush_hour=%0d valid=%0b, required %0d %0b",
                     rush_hour, rush_valid, RUSH_EN ? 2 : 0, RUSH_EN);
        end
        repeat (3) do_tick();
        burst(1'b1, 3, 3);
        burst(1'b0, 3, 0);
        sb_drained("rush");
        n_vec++;
        if (hour !== 3'd5 || rush_hour !== (RUSH_EN ? 3'd2 : 3'd0) || rush_valid !== RUSH_EN) begin
            n_err++;
            $display("FAIL rush_hold: hour=%0d rush_hour=%0d valid=%0b, required 5 %0d %0b",
                     hour, rush_hour, rush_valid, RUSH_EN ? 2 : 0, RUSH_EN);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_start();
        burst(1'b0, 2, 0);
        repeat (4) do_tick();
        n_vec++;
        if (hour !== 3'd4 || occupancy !== 2'd2) begin
            n_err++;
            $display("FAIL pre_reset: hour=%0d occ=%0d, required 4 2", hour, occupancy);
        end
        arrive_req = 1'b1;
        depart_req = 1'b1;
        reset = 1'b1;
        cyc();
        n_vec++;
        if ({entry_grant, exit_grant, hour, occupancy, full, lot_open, day_done,
             rush_hour, rush_valid} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_mid: eg=%0b xg=%0b hour=%0d occ=%0d full=%0b open=%0b done=%0b rh=%0d rv=%0b, required all 0",
                     entry_grant, exit_grant, hour, occupancy, full, lot_open, day_done,
                     rush_hour, rush_valid);
        end
        reset = 1'b0;
        repeat (3) cyc();
        arrive_req = 1'b0;
        depart_req = 1'b0;
        cyc();
        n_vec++;
        if (lot_open !== 1'b0 || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: open=%0b occ=%0d, required 0 0", lot_open, occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_both();
        test_day_end();
        test_empty_close();
        test_rush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
